// File: rtl/mac_engine_pkg.sv
// Shared types for the matrix MAC engine.
//   mac_op_t    : operation code issued by the MAC decoder
//   mac_state_t : engine sequencing states
//   MAC_N       : default matrix dimension
package mac_engine_pkg;

  localparam int MAC_N = 2;

  typedef enum logic [2:0] {
    MAC_MADD  = 3'd0,
    MAC_MSUB  = 3'd1,
    MAC_MMUL  = 3'd2,
    MAC_MLOAD = 3'd3
  } mac_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    EXEC  = 2'd2,
    DRAIN = 2'd3
  } mac_state_t;

  // Encodings outside the defined set are dropped at issue.
  function automatic logic mac_op_known(input mac_op_t op);
    case (op)
      MAC_MADD, MAC_MSUB, MAC_MMUL, MAC_MLOAD: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mac_engine_pe.sv
// mac_pe: single multiply-accumulate element, arithmetic modulo 2^DATA_W.
//   clk, reset : clock, async active-high reset (acc cleared)
//   en         : commit sum into the accumulator this cycle
//   clr        : start a new dot product (sum = a*b instead of acc + a*b)
//   a, b       : operands
//   sum        : combinational next accumulator value, used by the engine to
//                write C in the same cycle as the final product
module mac_pe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] prod;

  // Only the low DATA_W bits of the product are kept.
  assign prod = a * b;
  assign sum  = clr ? prod : acc + prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   acc <= '0;
    else if (en) acc <= sum;
  end

endmodule

// File: rtl/mac_engine.sv
// mac_engine: matrix MAC execution unit over internal NxN buffers A, B, C.
//   clk, reset          : clock, async active-high reset (aborts, clears buffers)
//   start, mac_op       : issue request, accepted when start & start_rdy
//   start_rdy           : engine idle and not in its done cycle
//   ld_valid/ld_data    : operand stream, A then B, row-major (ld_ready in LOAD)
//   out_valid/out_data  : result stream of C, row-major, held while out_ready=0
//   busy                : op in flight
//   done                : one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for an issue
// LOAD  | streaming 2*N*N words into A then B
// EXEC  | MADD/MSUB one element per cycle, MMUL one product per cycle
// DRAIN | presenting C element by element
module mac_engine
  import mac_engine_pkg::*;
#(
  parameter int N      = MAC_N,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  mac_op_t           mac_op,
  output logic              start_rdy,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int NN    = N * N;
  localparam int EL_W  = $clog2(NN);
  localparam int IDX_W = $clog2(N);

  mac_state_t        state_q, state_d;
  mac_op_t           op_q;
  logic [EL_W-1:0]   el_q;
  logic              bank_q;
  logic [IDX_W-1:0]  i_q, j_q, k_q;
  logic              done_q;
  logic [DATA_W-1:0] a_mem [NN];
  logic [DATA_W-1:0] b_mem [NN];
  logic [DATA_W-1:0] c_mem [NN];

  logic              accept, ld_fire, out_fire;
  logic              el_last, k_last, j_last, i_last, exec_last;
  logic [EL_W-1:0]   a_idx, b_idx, c_idx;
  logic [DATA_W-1:0] pe_sum;

  assign accept   = start && (state_q == IDLE) && !done_q;
  assign ld_fire  = ld_valid && (state_q == LOAD);
  assign out_fire = out_ready && (state_q == DRAIN);

  assign el_last   = (el_q == EL_W'(NN - 1));
  assign k_last    = (k_q == IDX_W'(N - 1));
  assign j_last    = (j_q == IDX_W'(N - 1));
  assign i_last    = (i_q == IDX_W'(N - 1));
  assign exec_last = (op_q == MAC_MMUL) ? (i_last && j_last && k_last) : el_last;

  assign a_idx = EL_W'(i_q) * EL_W'(N) + EL_W'(k_q);
  assign b_idx = EL_W'(k_q) * EL_W'(N) + EL_W'(j_q);
  assign c_idx = EL_W'(i_q) * EL_W'(N) + EL_W'(j_q);

  mac_pe #(.DATA_W(DATA_W)) u_pe (
    .clk   (clk),
    .reset (reset),
    .en    ((state_q == EXEC) && (op_q == MAC_MMUL)),
    .clr   (k_q == '0),
    .a     (a_mem[a_idx]),
    .b     (b_mem[b_idx]),
    .sum   (pe_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept && mac_op_known(mac_op))
               state_d = (mac_op == MAC_MLOAD) ? LOAD : EXEC;
      LOAD:  if (ld_fire && bank_q && el_last) state_d = IDLE;
      EXEC:  if (exec_last) state_d = DRAIN;
      DRAIN: if (out_fire && el_last) state_d = IDLE;
    endcase
  end

  // start_rdy is held low through the done cycle so a start coinciding with
  // done is taken one cycle later. All outputs come from registers only.
  always_comb begin
    start_rdy = (state_q == IDLE) && !done_q;
    ld_ready  = (state_q == LOAD);
    out_valid = (state_q == DRAIN);
    busy      = (state_q != IDLE);
    done      = done_q;
    out_data  = c_mem[el_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= MAC_MADD;
      el_q   <= '0;
      bank_q <= 1'b0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      done_q <= 1'b0;
      for (int e = 0; e < NN; e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
        c_mem[e] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept && mac_op_known(mac_op)) begin
          op_q   <= mac_op;
          el_q   <= '0;
          bank_q <= 1'b0;
          i_q    <= '0;
          j_q    <= '0;
          k_q    <= '0;
        end
        LOAD: if (ld_fire) begin
          if (!bank_q) a_mem[el_q] <= ld_data;
          else         b_mem[el_q] <= ld_data;
          el_q <= el_last ? '0 : el_q + 1'b1;
          if (el_last) bank_q <= 1'b1;
          if (el_last && bank_q) done_q <= 1'b1;
        end
        EXEC: if (op_q == MAC_MMUL) begin
          if (k_last) begin
            c_mem[c_idx] <= pe_sum;
            k_q <= '0;
            if (j_last) begin
              j_q <= '0;
              i_q <= i_last ? '0 : i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end else begin
          c_mem[el_q] <= (op_q == MAC_MSUB) ? a_mem[el_q] - b_mem[el_q]
                                            : a_mem[el_q] + b_mem[el_q];
          el_q <= el_last ? '0 : el_q + 1'b1;
        end
        DRAIN: if (out_fire) begin
          el_q <= el_last ? '0 : el_q + 1'b1;
          if (el_last) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_engine.sv
module tb_mac_engine;
  import mac_engine_pkg::*;

  localparam int N  = 2;
  localparam int NN = N * N;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  mac_op_t     mac_op;
  logic        start_rdy;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  mac_engine #(.N(N), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .mac_op(mac_op), .start_rdy(start_rdy),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  int tests = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];
  bit rand_ready = 0;
  bit hold_arm = 0;
  int hold_cnt = 0;

  // reference matrices
  logic [31:0] ma [N][N];
  logic [31:0] mb [N][N];
  logic [31:0] mc [N][N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: decides out_ready for the coming edge and scores the element on offer.
  always @(negedge clk) begin
    if (hold_arm && out_valid === 1'b1) begin
      hold_arm = 0;
      hold_cnt = 5;
    end
    if (hold_cnt > 0) begin
      out_ready = 1'b0;
      hold_cnt--;
    end else begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (done === 1'b1) done_cnt++;
    if (out_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_unexpected: got 0x%08h expected no element", out_data);
      end else begin
        if (out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL drain_data: got 0x%08h expected 0x%08h", out_data, exp_q[0]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = '0; mb[i][j] = '0; mc[i][j] = '0;
      end
  endtask

  task automatic model_push(input mac_op_t op);
    logic [31:0] s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        case (op)
          MAC_MADD: mc[i][j] = ma[i][j] + mb[i][j];
          MAC_MSUB: mc[i][j] = ma[i][j] - mb[i][j];
          default: begin
            s = 0;
            for (int k = 0; k < N; k++) s = s + ma[i][k] * mb[k][j];
            mc[i][j] = s;
          end
        endcase
        exp_q.push_back(mc[i][j]);
      end
  endtask

  task automatic issue(input mac_op_t op, output bit ok);
    int t = 0;
    while (start_rdy !== 1'b1 && t < 200) begin tick(); t++; end
    ok = (start_rdy === 1'b1);
    if (!ok) begin
      tests++; errors++;
      $display("FAIL issue_timeout: start_rdy=%b expected 1", start_rdy);
      return;
    end
    start = 1'b1;
    mac_op = op;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done !== 1'b1 && t < 300) begin tick(); t++; end
    if (done !== 1'b1) begin
      tests++; errors++;
      $display("FAIL done_timeout: done=%b expected 1", done);
      return;
    end
    check("done_cycle_start_rdy", {31'd0, start_rdy}, 32'd0);
    check("done_cycle_busy", {31'd0, busy}, 32'd0);
    tick();
    check("after_done_start_rdy", {31'd0, start_rdy}, 32'd1);
    tick(); tick();
    check("done_pulse_count", done_cnt - d0, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic load_op(input logic [31:0] words[2*NN], input int mode, input bit spurious);
    int w = 0, t = 0, d0 = done_cnt;
    bit ok, fire;
    issue(MAC_MLOAD, ok);
    if (!ok) return;
    while (w < 2 * NN && t < 200) begin
      ld_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(t % 2 == 0) : 1'($urandom_range(0, 1));
      ld_data  = words[w];
      if (spurious) begin start = (t == 1); mac_op = MAC_MMUL; end
      fire = ld_valid && (ld_ready === 1'b1);
      tick();
      if (fire) w++;
      t++;
    end
    ld_valid = 1'b0;
    start = 1'b0;
    check("load_words", w, 2 * NN);
    for (int e = 0; e < NN; e++) begin
      ma[e / N][e % N] = words[e];
      mb[e / N][e % N] = words[NN + e];
    end
    wait_done(d0);
  endtask

  task automatic run_op(input mac_op_t op, input bit pulse_mid);
    int cnt = 0, d0 = done_cnt;
    bit ok, busy_bad = 0;
    model_push(op);
    issue(op, ok);
    if (!ok) begin exp_q.delete(); return; end
    while (out_valid !== 1'b1 && cnt < 100) begin
      if (busy !== 1'b1) busy_bad = 1;
      if (pulse_mid) begin start = (cnt == 2); mac_op = MAC_MADD; end
      cnt++;
      tick();
    end
    start = 1'b0;
    check("exec_cycles", cnt, (op == MAC_MMUL) ? N * N * N : N * N);
    check("exec_busy", {31'd0, busy_bad}, 32'd0);
    wait_done(d0);
  endtask

  logic [31:0] words [2*NN];

  initial begin
    bit ok;
    int d0, t;
    reset = 1'b1; start = 1'b0; mac_op = MAC_MADD; ld_valid = 1'b0; ld_data = '0;
    model_clear();
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start_rdy", {31'd0, start_rdy}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    reset = 1'b0;
    tick();

    // directed operands 1..8, then MMUL / MADD / MSUB
    for (int e = 0; e < 2 * NN; e++) words[e] = e + 1;
    load_op(words, 0, 0);
    run_op(MAC_MMUL, 0);
    run_op(MAC_MADD, 0);
    run_op(MAC_MSUB, 0);

    // stalled drain: first element held 5 cycles
    hold_arm = 1;
    run_op(MAC_MMUL, 0);

    // toggling ld_valid with a start during LOAD, then a start during EXEC
    for (int e = 0; e < 2 * NN; e++) words[e] = 32'h100 * (e + 3) + 7;
    load_op(words, 1, 1);
    run_op(MAC_MMUL, 1);

    // unknown encoding is dropped
    d0 = done_cnt;
    start = 1'b1; mac_op = mac_op_t'(3'd5);
    tick();
    start = 1'b0;
    tick(); tick();
    check("unknown_op_busy", {31'd0, busy}, 32'd0);
    check("unknown_op_done", done_cnt - d0, 32'd0);

    // reset in the middle of a stalled drain
    for (int e = 0; e < 2 * NN; e++) words[e] = e + 1;
    load_op(words, 0, 0);
    model_push(MAC_MADD);
    hold_arm = 1;
    d0 = done_cnt;
    issue(MAC_MADD, ok);
    t = 0;
    while (out_valid !== 1'b1 && t < 50) begin tick(); t++; end
    check("drain_reached", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) tick();
    check("midrst_start_rdy", {31'd0, start_rdy}, 32'd1);
    check("midrst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    model_clear();
    repeat (8) tick();
    check("midrst_no_done", done_cnt - d0, 32'd0);
    run_op(MAC_MADD, 0);
    run_op(MAC_MMUL, 0);

    // wrap-around product, then reset during EXEC
    for (int e = 0; e < NN; e++) begin words[e] = 32'hFFFF_FFFF; words[NN + e] = 32'd2; end
    load_op(words, 0, 0);
    run_op(MAC_MMUL, 0);
    d0 = done_cnt;
    issue(MAC_MMUL, ok);
    tick(); tick();
    check("exec_before_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("exec_rst_busy", {31'd0, busy}, 32'd0);
    check("exec_rst_out_valid", {31'd0, out_valid}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    model_clear();
    t = 0;
    repeat (12) begin if (out_valid === 1'b1) t++; tick(); end
    check("exec_rst_no_drain", t, 32'd0);
    check("exec_rst_no_done", done_cnt - d0, 32'd0);

    // randomized operands, ops and back-pressure
    rand_ready = 1;
    for (int r = 0; r < 4; r++) begin
      for (int e = 0; e < 2 * NN; e++) words[e] = $urandom();
      load_op(words, 2, 0);
      run_op(mac_op_t'($urandom_range(0, 2)), 0);
      run_op(MAC_MMUL, 0);
    end
    rand_ready = 0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
